ps2_key_matrix: RTL
===================

# ps2_key_matrix

- Converts the PS/2 scancode byte stream into an emulated UT-88 key matrix, modifier flags and a hex-key FIFO for the monitor keypad.
- Sits between `PS2_Controller` and the CPU port decoder, all in one clock domain.
- Generalises the top-level keyboard logic with:
  - parametrised matrix size and FIFO depth;
  - E0/E1 prefix decoding;
  - held-key caps handling;
  - a flush input.

## Interface
Parameters:
- `COLS`, 8, number of matrix columns (1..8).
- `ROWS`, 7, number of matrix rows (1..8).
- `FIFO_DEPTH`, 4, hex-key FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  single system clock; every register is clocked on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received scancode byte.
- `rx_valid`  in  1  one-cycle strobe, already synchronous to `clk`.
- `flush`  in  1  release all keys and empty the FIFO.
- `col_sel`  in  COLS  active-low column select (CPU port 07 value).
- `row_data`  out  ROWS  active-low row readback.
- `any_key`  out  1  any matrix key held.
- `shift`  out  1  left or right Shift held.
- `caps`  out  1  Caps Lock toggle state.
- `key_code`  out  8  FIFO head (show-ahead).
- `key_valid`  out  1  FIFO non-empty.
- `key_pop`  in  1  consume FIFO head.
- `overflow`  out  1  sticky: a push was dropped.

## Operation
Prefix FSM, advanced only on `rx_valid`:
- States: IDLE, BRK, EXT, EXT_BRK, SKIP.
- From IDLE: F0→BRK, E0→EXT, E1→SKIP with skip counter = 7. Any other byte emits a make event (ext=0) and stays in IDLE.
- From EXT: F0→EXT_BRK; any other byte emits make (ext=1) →IDLE.
- From BRK: any byte emits break (ext=0) →IDLE.
- From EXT_BRK: any byte emits break (ext=1) →IDLE.
- SKIP: decrements the counter on each byte; →IDLE when the counter reaches 0. This drops the Pause sequence.
- A byte FA or AA in any state except SKIP is ignored and leaves the state unchanged.

Event handling:
- Shift: 12 and 59 (ext=0) set/clear separate left/right bits; `shift` = OR of the two. They never touch the matrix.
- Caps Lock, 58: on make, `caps` toggles only if the internal caps_held bit is 0, then caps_held is set. On break, caps_held is cleared. Typematic repeats therefore do not re-toggle.
- Matrix: `map_matrix(ext, code)` returns {hit, col, row}.
  - Make sets `mat[col][row]`; break clears it.
  - Ignored when !hit, col ≥ COLS or row ≥ ROWS.
  - Repeated makes are idempotent.
- Hex FIFO: on every make with ext=0, `map_hex(code)` hit pushes the value, including typematic repeats. Examples: 45→10, 16→01, 1C→0A, 76→80.
- FIFO full with a push and no pop: the push is dropped and `overflow` is set. It stays set until reset.
- FIFO full with push and pop in the same cycle: both happen, `overflow` unchanged.
- Pop when empty: ignored.

Readback:
- `row_data[r]` = ~OR over c where `col_sel[c]`==0 of `mat[c][r]`.
- `col_sel` all ones → `row_data` all ones.
- `any_key` = OR of all `mat` bits.

Flush:
- Clears `mat`, both shift bits, caps_held, the FIFO and the skip counter; FSM→IDLE.
- `caps` and `overflow` are kept.
- `flush` takes priority over a simultaneous `rx_valid`; that byte is discarded.

## Timing
- Reset values:
  - `row_data` all ones;
  - `any_key`, `shift`, `caps`, `key_valid`, `overflow` = 0;
  - `key_code` = 00;
  - FSM IDLE, `mat` zero, FIFO empty.
- A byte is accepted at edge n. `mat`, `shift`, `caps`, `any_key`, FIFO status and `key_code` reflect it after edge n.
- `row_data` is registered, so it reflects `mat`/`col_sel` one edge later (after n+1). A `col_sel` change is likewise visible one edge later.
- `key_pop` at edge n: the next entry (or `key_valid`=0) appears after edge n.
- `rst` assertion clears everything immediately, including mid-prefix or mid-SKIP.

## Structure
Package `ut88_kbd_pkg`:
- FSM state enum.
- Constants BRK_CODE=F0, EXT_CODE=E0, PAUSE_CODE=E1, PAUSE_SKIP=7.
- `map_matrix` and `map_hex` functions. Required matrix entries:
  - col0: row0=45, row1=16, row2=1E;
  - col7: row0=E0-74, row3=5A.

Sub-module `kbd_fifo`:
- Parametrised depth, 8-bit, show-ahead.
- Outputs count, full and empty.

## Test plan
- Byte 16 → `mat[0][1]`=1; `col_sel`=FE gives `row_data`=7D two edges after the byte; FIFO head 01. Then F0 16 → `row_data`=7F, `any_key`=0.
- E0 74 → `mat[7][0]`=1, no FIFO push; plain 74 → `mat[7][0]` unchanged. E0 F0 74 → cleared.
- 58 58 58 F0 58 → `caps`=1. A further 58 → `caps`=0.
- E1 14 77 E1 F0 14 F0 77, then 45 → only 45 is registered (`mat[0][0]`=1, FIFO head 10).
- 5 hex makes with no pop (`FIFO_DEPTH`=4) → `key_valid`=1, the 5th is dropped, `overflow`=1.
  - Full FIFO with push+pop in the same cycle → count stays 4, no new overflow.
- Press 16 and 12, send F0, then `flush` coincident with byte 16 → `mat` zero, `shift`=0, FSM IDLE, FIFO empty. A following 45 is treated as a make.

Source files
------------

// File: rtl/ps2_key_matrix_pkg.sv
// ut88_kbd_pkg: shared types, scancode constants and lookup tables for the
// PS/2 to UT-88 keyboard bridge.
//   kbd_state_t  - prefix decoder states
//   mat_map_t    - {hit, col, row} result of map_matrix()
//   hex_map_t    - {hit, val} result of map_hex()
package ut88_kbd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK,
        ST_SKIP
    } kbd_state_t;

    localparam logic [7:0] BRK_CODE    = 8'hF0;
    localparam logic [7:0] EXT_CODE    = 8'hE0;
    localparam logic [7:0] PAUSE_CODE  = 8'hE1;
    localparam logic [7:0] ACK_CODE    = 8'hFA;
    localparam logic [7:0] BAT_CODE    = 8'hAA;
    localparam logic [7:0] LSHIFT_CODE = 8'h12;
    localparam logic [7:0] RSHIFT_CODE = 8'h59;
    localparam logic [7:0] CAPS_CODE   = 8'h58;
    localparam logic [2:0] PAUSE_SKIP  = 3'd7;

    typedef struct packed {
        logic       hit;
        logic [2:0] col;
        logic [2:0] row;
    } mat_map_t;

    typedef struct packed {
        logic       hit;
        logic [7:0] val;
    } hex_map_t;

    // Scancode (with E0 flag) to matrix position.
    function automatic mat_map_t map_matrix(input logic ext, input logic [7:0] code);
        mat_map_t m;
        m = '0;
        case ({ext, code})
            9'h045: m = {1'b1, 3'd0, 3'd0};
            9'h016: m = {1'b1, 3'd0, 3'd1};
            9'h01E: m = {1'b1, 3'd0, 3'd2};
            9'h026: m = {1'b1, 3'd0, 3'd3};
            9'h025: m = {1'b1, 3'd0, 3'd4};
            9'h02E: m = {1'b1, 3'd0, 3'd5};
            9'h036: m = {1'b1, 3'd0, 3'd6};
            9'h03D: m = {1'b1, 3'd1, 3'd0};
            9'h03E: m = {1'b1, 3'd1, 3'd1};
            9'h046: m = {1'b1, 3'd1, 3'd2};
            9'h174: m = {1'b1, 3'd7, 3'd0};
            9'h16B: m = {1'b1, 3'd7, 3'd1};
            9'h175: m = {1'b1, 3'd7, 3'd2};
            9'h05A: m = {1'b1, 3'd7, 3'd3};
            9'h172: m = {1'b1, 3'd7, 3'd4};
            9'h066: m = {1'b1, 3'd7, 3'd5};
            9'h029: m = {1'b1, 3'd7, 3'd6};
            default: m = '0;
        endcase
        return m;
    endfunction

    // Scancode to monitor keypad value ('0' is coded as 10h, Esc as 80h).
    function automatic hex_map_t map_hex(input logic [7:0] code);
        hex_map_t h;
        h.hit = 1'b1;
        case (code)
            8'h45: h.val = 8'h10;
            8'h16: h.val = 8'h01;
            8'h1E: h.val = 8'h02;
            8'h26: h.val = 8'h03;
            8'h25: h.val = 8'h04;
            8'h2E: h.val = 8'h05;
            8'h36: h.val = 8'h06;
            8'h3D: h.val = 8'h07;
            8'h3E: h.val = 8'h08;
            8'h46: h.val = 8'h09;
            8'h1C: h.val = 8'h0A;
            8'h32: h.val = 8'h0B;
            8'h21: h.val = 8'h0C;
            8'h23: h.val = 8'h0D;
            8'h24: h.val = 8'h0E;
            8'h2B: h.val = 8'h0F;
            8'h76: h.val = 8'h80;
            default: begin
                h.hit = 1'b0;
                h.val = 8'h00;
            end
        endcase
        return h;
    endfunction

endpackage

// File: rtl/ps2_key_matrix_if.sv
// ps2_key_matrix_if: bundle between the scancode source / CPU side (master)
// and the keyboard bridge (slave).
//   rx_data/rx_valid  scancode byte + strobe
//   flush             release all keys, empty FIFO
//   col_sel/row_data  active-low matrix scan
//   any_key/shift/caps key state flags
//   key_code/key_valid/key_pop  show-ahead hex FIFO
//   overflow          sticky FIFO drop flag
interface ps2_key_matrix_if #(
    parameter int COLS = 8,
    parameter int ROWS = 7
);
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic            flush;
    logic [COLS-1:0] col_sel;
    logic [ROWS-1:0] row_data;
    logic            any_key;
    logic            shift;
    logic            caps;
    logic [7:0]      key_code;
    logic            key_valid;
    logic            key_pop;
    logic            overflow;

    modport master (
        output rx_data, rx_valid, flush, col_sel, key_pop,
        input  row_data, any_key, shift, caps, key_code, key_valid, overflow
    );

    modport slave (
        input  rx_data, rx_valid, flush, col_sel, key_pop,
        output row_data, any_key, shift, caps, key_code, key_valid, overflow
    );
endinterface

// File: rtl/ps2_key_matrix_fifo.sv
// kbd_fifo: show-ahead FIFO for monitor keypad codes.
//   clk, rst (async active-low), flush (sync clear)
//   push/din, pop/dout (dout = head, 0 when empty), count, full, empty
// A push while full is accepted only if a pop frees a slot in the same cycle.
module kbd_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/ps2_key_matrix.sv
// ps2_key_matrix: turns the PS/2 scancode stream into the UT-88 key matrix,
// Shift/Caps flags and a hex-key FIFO.
//   clk  system clock
//   rst  asynchronous active-low reset
//   bus  ps2_key_matrix_if.slave (scancodes in, matrix/flags/FIFO out)
module ps2_key_matrix
    import ut88_kbd_pkg::*;
#(
    parameter int COLS       = 8,
    parameter int ROWS       = 7,
    parameter int FIFO_DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    ps2_key_matrix_if.slave bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    kbd_state_t                 state, state_nx;
    logic [2:0]                 skip_cnt, skip_nx;
    logic                       rx_ignore;
    logic                       ev_vld_p0, ev_make_p0, ev_ext_p0;
    logic [7:0]                 ev_code_p0;
    mat_map_t                   mm;
    hex_map_t                   hx;
    logic                       mat_we;
    logic [COLS-1:0][ROWS-1:0]  mat;
    logic                       shift_l, shift_r, caps_q, caps_held;
    logic                       fifo_push, fifo_full, fifo_empty, overflow_q;
    logic [7:0]                 fifo_dout;
    logic [CNT_W-1:0]           fifo_count;
    logic [ROWS-1:0]            row_nx, row_p1;
    logic                       row_hit;

    // ACK/BAT bytes from the keyboard are transparent, except inside Pause.
    assign rx_ignore = ((bus.rx_data == ACK_CODE) || (bus.rx_data == BAT_CODE))
                       && (state != ST_SKIP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            skip_cnt <= '0;
        end else begin
            state    <= state_nx;
            skip_cnt <= skip_nx;
        end
    end

    always_comb begin
        state_nx = state;
        skip_nx  = skip_cnt;
        if (bus.flush) begin
            state_nx = ST_IDLE;
            skip_nx  = '0;
        end else if (bus.rx_valid && !rx_ignore) begin
            case (state)
                ST_IDLE: begin
                    if (bus.rx_data == BRK_CODE)
                        state_nx = ST_BRK;
                    else if (bus.rx_data == EXT_CODE)
                        state_nx = ST_EXT;
                    else if (bus.rx_data == PAUSE_CODE) begin
                        state_nx = ST_SKIP;
                        skip_nx  = PAUSE_SKIP;
                    end
                end
                ST_EXT:     state_nx = (bus.rx_data == BRK_CODE) ? ST_EXT_BRK : ST_IDLE;
                ST_BRK:     state_nx = ST_IDLE;
                ST_EXT_BRK: state_nx = ST_IDLE;
                ST_SKIP: begin
                    skip_nx = skip_cnt - 3'd1;
                    if (skip_cnt <= 3'd1)
                        state_nx = ST_IDLE;
                end
                default:    state_nx = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ev_vld_p0  = 1'b0;
        ev_make_p0 = 1'b0;
        ev_ext_p0  = 1'b0;
        ev_code_p0 = bus.rx_data;
        if (bus.rx_valid && !bus.flush && !rx_ignore) begin
            case (state)
                ST_IDLE: begin
                    if ((bus.rx_data != BRK_CODE) && (bus.rx_data != EXT_CODE)
                        && (bus.rx_data != PAUSE_CODE)) begin
                        ev_vld_p0  = 1'b1;
                        ev_make_p0 = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (bus.rx_data != BRK_CODE) begin
                        ev_vld_p0  = 1'b1;
                        ev_make_p0 = 1'b1;
                        ev_ext_p0  = 1'b1;
                    end
                end
                ST_BRK:     ev_vld_p0 = 1'b1;
                ST_EXT_BRK: begin
                    ev_vld_p0 = 1'b1;
                    ev_ext_p0 = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ---- stage p0: decoded event updates key state ----
    assign mm     = map_matrix(ev_ext_p0, ev_code_p0);
    assign hx     = map_hex(ev_code_p0);
    assign mat_we = ev_vld_p0 && mm.hit && (int'(mm.col) < COLS) && (int'(mm.row) < ROWS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            mat <= '0;
        else if (bus.flush)
            mat <= '0;
        else if (mat_we) begin
            for (int c = 0; c < COLS; c++)
                for (int r = 0; r < ROWS; r++)
                    if ((c == int'(mm.col)) && (r == int'(mm.row)))
                        mat[c][r] <= ev_make_p0;
        end
    end

    // caps_held suppresses re-toggling on typematic repeats of Caps Lock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_l   <= 1'b0;
            shift_r   <= 1'b0;
            caps_q    <= 1'b0;
            caps_held <= 1'b0;
        end else if (bus.flush) begin
            shift_l   <= 1'b0;
            shift_r   <= 1'b0;
            caps_held <= 1'b0;
        end else if (ev_vld_p0 && !ev_ext_p0) begin
            case (ev_code_p0)
                LSHIFT_CODE: shift_l <= ev_make_p0;
                RSHIFT_CODE: shift_r <= ev_make_p0;
                CAPS_CODE: begin
                    if (ev_make_p0) begin
                        if (!caps_held)
                            caps_q <= ~caps_q;
                        caps_held <= 1'b1;
                    end else begin
                        caps_held <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fifo_push = ev_vld_p0 && ev_make_p0 && !ev_ext_p0 && hx.hit;

    kbd_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.flush),
        .push  (fifo_push),
        .din   (hx.val),
        .pop   (bus.key_pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        assert (fifo_count <= CNT_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            overflow_q <= 1'b0;
        else if (fifo_push && fifo_full && !bus.key_pop)
            overflow_q <= 1'b1;
    end

    // ---- stage p1: registered row readback ----
    always_comb begin
        row_nx  = '1;
        row_hit = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            row_hit = 1'b0;
            for (int c = 0; c < COLS; c++)
                row_hit = row_hit | (mat[c][r] & ~bus.col_sel[c]);
            row_nx[r] = ~row_hit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            row_p1 <= '1;
        else
            row_p1 <= row_nx;
    end

    assign bus.row_data  = row_p1;
    assign bus.any_key   = |mat;
    assign bus.shift     = shift_l | shift_r;
    assign bus.caps      = caps_q;
    assign bus.key_code  = fifo_dout;
    assign bus.key_valid = !fifo_empty;
    assign bus.overflow  = overflow_q;
endmodule
